// File: rtl/scmp_bus_if.sv
// scmp_bus_if: bridges the core's strobe bus (ADS/RD/WR) to a req/ack memory port.
//   clk, rst        : clock; asynchronous active-high reset
//   cpu_ads_n       : address strobe; cpu_d_o carries {H,D,I,R,A15..A12} with it
//   cpu_rd_n/wr_n   : read / write strobes; cpu_d_o carries write data with WR
//   cpu_addr        : low 12 address bits
//   cpu_d_i         : registered read data (0xFF after a read timeout)
//   cpu_hold        : combinational stretch request while an access is incomplete
//   mem_addr/wdata  : latched address / write data
//   mem_req/we/ack  : request held until ack or timeout; we valid with req
//   mem_rdata       : read data, valid with mem_ack
//   st_flags        : latched cycle flags {H,D,I,R}
//   bus_err         : sticky protocol/timeout error, cleared only by reset
module scmp_bus_if #(
  parameter int unsigned WAIT_MIN    = 1,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ads_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_d_o,
  output logic [7:0]  cpu_d_i,
  output logic        cpu_hold,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic [3:0]  st_flags,
  output logic        bus_err
);

  localparam int unsigned WCNT_W = 4;
  localparam int unsigned TCNT_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_ACCESS, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic [15:0]         mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic [3:0]          st_flags_q, st_flags_d;
  logic [7:0]          cpu_d_i_q, cpu_d_i_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                bus_err_q, bus_err_d;
  logic                ack_seen_q, ack_seen_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [TCNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic                ack_now;

  // An ack only counts while a request is outstanding; stray acks are ignored.
  assign ack_now = mem_req_q & mem_ack;

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    st_flags_d  = st_flags_q;
    cpu_d_i_d   = cpu_d_i_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    bus_err_d   = bus_err_q;
    ack_seen_d  = ack_seen_q;
    wait_cnt_d  = wait_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;

    // Address strobe while a cycle is in flight is a protocol error.
    if (!cpu_ads_n && (state_q != ST_IDLE)) bus_err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!cpu_ads_n) begin
          mem_addr_d = {cpu_d_o[3:0], cpu_addr};
          st_flags_d = cpu_d_o[7:4];
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!cpu_rd_n && !cpu_wr_n) begin
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (!cpu_rd_n || !cpu_wr_n) begin
          if (!cpu_wr_n) mem_wdata_d = cpu_d_o;
          mem_req_d  = 1'b1;
          mem_we_d   = !cpu_wr_n;
          ack_seen_d = 1'b0;
          wait_cnt_d = '0;
          tmo_cnt_d  = '0;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_cnt_q != WCNT_W'(WAIT_MIN)) wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        if (ack_now) begin
          mem_req_d  = 1'b0;
          ack_seen_d = 1'b1;
          if (!mem_we_q) cpu_d_i_d = mem_rdata;
        end
        if ((ack_seen_q || ack_now) && (wait_cnt_q == WCNT_W'(WAIT_MIN))) begin
          state_d = ST_DONE;
        end else if (!ack_seen_q && !ack_now) begin
          // Timeout only runs while still waiting for the ack.
          if (tmo_cnt_q == TCNT_W'(ACK_TIMEOUT - 1)) begin
            mem_req_d = 1'b0;
            bus_err_d = 1'b1;
            if (!mem_we_q) cpu_d_i_d = 8'hFF;
            state_d   = ST_DONE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TCNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (cpu_rd_n && cpu_wr_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      st_flags_q  <= '0;
      cpu_d_i_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      ack_seen_q  <= 1'b0;
      wait_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      st_flags_q  <= st_flags_d;
      cpu_d_i_q   <= cpu_d_i_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      bus_err_q   <= bus_err_d;
      ack_seen_q  <= ack_seen_d;
      wait_cnt_q  <= wait_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  // Hold stretches the core from the first strobe until the access finishes.
  assign cpu_hold  = ((state_q == ST_ADDR) && (!cpu_rd_n || !cpu_wr_n)) ||
                     (state_q == ST_ACCESS);
  assign cpu_d_i   = cpu_d_i_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign st_flags  = st_flags_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign bus_err   = bus_err_q;

endmodule

// File: doc/scmp_bus_if.md
SCMP_BUS_IF -- requirements
Module: scmp_bus_if

Interface
REQ-001 SHALL have parameter WAIT_MIN, default 1: minimum cycles from mem_req assertion to data completion (range 0-15).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 64: cycles to wait for mem_ack before aborting an access (range 1-255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-005 SHALL have port cpu_ads_n, input, 1 bit: core address strobe, active low.
REQ-006 SHALL have port cpu_rd_n, input, 1 bit: core read strobe, active low.
REQ-007 SHALL have port cpu_wr_n, input, 1 bit: core write strobe, active low.
REQ-008 SHALL have port cpu_addr, input, 12 bits: core low address.
REQ-009 SHALL have port cpu_d_o, input, 8 bits: core data out; carries {H,D,I,R,A15..A12} during ADS, write data during WR.
REQ-010 SHALL have port cpu_d_i, output, 8 bits: registered read data to core.
REQ-011 SHALL have port cpu_hold, output, 1 bit: stretch request to core; high while an access is incomplete.
REQ-012 SHALL have port mem_addr, output, 16 bits: latched full address.
REQ-013 SHALL have port mem_wdata, output, 8 bits: latched write data.
REQ-014 SHALL have port mem_rdata, input, 8 bits: memory read data, valid with mem_ack.
REQ-015 SHALL have port mem_req, output, 1 bit: access request, held until mem_ack or timeout.
REQ-016 SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read; valid while mem_req is high.
REQ-017 SHALL have port mem_ack, input, 1 bit: one-cycle completion from memory.
REQ-018 SHALL have port st_flags, output, 4 bits: latched cycle flags {H,D,I,R}.
REQ-019 SHALL have port bus_err, output, 1 bit: sticky protocol/timeout error.

Function
REQ-020 SHALL implement FSM states IDLE, ADDR, ACCESS, DONE.
REQ-021 IDLE: cpu_ads_n low at a clock edge SHALL latch mem_addr = {cpu_d_o[3:0], cpu_addr} and st_flags = cpu_d_o[7:4], then go to ADDR.
REQ-022 ADDR: cpu_rd_n low SHALL assert mem_req with mem_we=0 on the next edge and go to ACCESS.
REQ-023 ADDR: cpu_wr_n low SHALL latch mem_wdata = cpu_d_o, assert mem_req with mem_we=1 on the next edge, and go to ACCESS.
REQ-024 ADDR: cpu_rd_n and cpu_wr_n both low SHALL set bus_err, issue no access, and go to IDLE.
REQ-025 ACCESS: a 4-bit wait counter SHALL start at 0 on entry and increment each cycle, saturating at WAIT_MIN.
REQ-026 ACCESS: mem_ack SHALL drop mem_req on the next edge; for a read it SHALL latch cpu_d_i = mem_rdata on the same edge.
REQ-027 ACCESS: the transition to DONE SHALL occur only once mem_ack has been seen and the wait counter has reached WAIT_MIN; an early ack SHALL be remembered in a flag.
REQ-028 ACCESS: if ACK_TIMEOUT cycles pass without mem_ack, the block SHALL drop mem_req, set bus_err, set cpu_d_i = 8'hFF for a read, and go to DONE.
REQ-029 cpu_hold SHALL be high combinationally in ADDR whenever a strobe is low, and high throughout ACCESS; it SHALL be low in IDLE and DONE.
REQ-030 DONE: the block SHALL return to IDLE once cpu_rd_n and cpu_wr_n are both high; cpu_d_i SHALL hold its value until the next read completes.
REQ-031 A cpu_ads_n low outside IDLE SHALL be ignored for latching and SHALL set bus_err.
REQ-032 mem_addr, st_flags and mem_wdata SHALL change only on the events in REQ-021 and REQ-023.
REQ-033 Address arithmetic SHALL NOT be performed: mem_addr is a pure 16-bit latch, and no wrap handling is needed.
REQ-034 bus_err SHALL clear only on reset.

Reset
REQ-035 On rst high, the block SHALL immediately go to IDLE and set mem_req=0, mem_we=0, cpu_hold=0, cpu_d_i=0, mem_addr=0, mem_wdata=0, st_flags=0, bus_err=0, and all counters to 0.
REQ-036 A reset during ACCESS SHALL abort the access without waiting for mem_ack; a late mem_ack arriving in IDLE SHALL be ignored.

Verification
REQ-037 Read: ADS with cpu_d_o=8'h25 and cpu_addr=12'h3A0, then RD low, mem_ack after 3 cycles with rdata 8'h5C -> mem_addr=16'h53A0, st_flags=4'h2, mem_we=0, cpu_d_i=8'h5C, cpu_hold low in DONE.
REQ-038 Write: ADS with addr 16'h0FFF, then WR low with data 8'hA7, immediate ack -> mem_we=1, mem_wdata=8'hA7, DONE reached no earlier than WAIT_MIN=1 cycle after request.
REQ-039 Timeout: read with mem_ack never asserted -> mem_req drops after exactly 64 cycles, cpu_d_i=8'hFF, bus_err=1.
REQ-040 Protocol errors: RD and WR low together in ADDR -> no mem_req and bus_err=1; ADS pulse during ACCESS -> mem_addr unchanged and bus_err=1.
REQ-041 Reset mid-access: rst pulsed while mem_req=1 -> all outputs 0 asynchronously; an ack one cycle later leaves cpu_d_i=0.
